// File: rtl/i2s_rx_slave.sv
// I2S receiver slave: oversamples BCLK/WS/SD in the clk_ref domain and presents
// L/R frames on a valid/ready port. Define I2S_RX_OVERFLOW_CNT_EN for the dropped-frame counter.
module i2s_rx_slave #(
    parameter int SLOT_BITS    = 24,
    parameter int SAMPLE_WIDTH = 24
) (
    input  logic                    clk_ref,
    input  logic                    reset_n,
    input  logic                    i2s_bclk,
    input  logic                    i2s_ws,
    input  logic                    i2s_sd,
    output logic [SAMPLE_WIDTH-1:0] out_left,
    output logic [SAMPLE_WIDTH-1:0] out_right,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overflow,
    output logic [15:0]             overflow_count
);

    localparam int CNT_W = $clog2(SLOT_BITS + 1);

    typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;

    logic [2:0]              raw_in;
    logic [2:0]              meta_reg;
    logic [2:0]              sync_reg;
    logic                    bclk_dly_reg;
    logic                    ws_prev_reg;
    logic [CNT_W-1:0]        bit_cnt_reg;
    logic [SAMPLE_WIDTH-1:0] word_reg;
    logic [SAMPLE_WIDTH-1:0] cur_word;
    logic [SAMPLE_WIDTH-1:0] left_stage_reg;
    logic [SAMPLE_WIDTH-1:0] out_left_reg;
    logic [SAMPLE_WIDTH-1:0] out_right_reg;
    logic                    out_valid_reg;
    logic                    overflow_reg;
    state_t                  state_reg;
    state_t                  state_next;
    logic                    rise_stb;
    logic                    ws_now;
    logic                    sd_now;
    logic                    word_edge;
    logic                    left_done;
    logic                    frame_done;

    assign raw_in = {i2s_sd, i2s_ws, i2s_bclk};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            always_ff @(posedge clk_ref) begin
                if (!reset_n) begin
                    meta_reg[gi] <= 1'b0;
                    sync_reg[gi] <= 1'b0;
                end else begin
                    meta_reg[gi] <= raw_in[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign rise_stb  = sync_reg[0] & ~bclk_dly_reg;
    assign ws_now    = sync_reg[1];
    assign sd_now    = sync_reg[2];
    assign word_edge = rise_stb && (ws_now != ws_prev_reg);

    // Bits land directly at their MSB-first position, so a short word is
    // already left-justified over zeros and bits past SAMPLE_WIDTH never match.
    generate
        for (genvar gi = 0; gi < SAMPLE_WIDTH; gi++) begin : g_place
            localparam logic [CNT_W-1:0] POS = CNT_W'(SAMPLE_WIDTH - 1 - gi);
            assign cur_word[gi] = (bit_cnt_reg == POS) ? sd_now : word_reg[gi];
        end
    endgenerate

    // Channels alternate strictly, so one accumulator serves both words.
    always_ff @(posedge clk_ref) begin
        if (!reset_n) begin
            bclk_dly_reg   <= 1'b0;
            ws_prev_reg    <= 1'b0;
            bit_cnt_reg    <= '0;
            word_reg       <= '0;
            left_stage_reg <= '0;
        end else begin
            bclk_dly_reg <= sync_reg[0];
            if (rise_stb) begin
                ws_prev_reg <= ws_now;
                if (word_edge) begin
                    word_reg    <= '0;
                    bit_cnt_reg <= '0;
                end else begin
                    word_reg <= cur_word;
                    if (bit_cnt_reg != CNT_W'(SLOT_BITS)) begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
            end
            if (left_done) begin
                left_stage_reg <= cur_word;
            end
        end
    end

    always_ff @(posedge clk_ref) begin
        if (!reset_n) begin
            state_reg <= HUNT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (word_edge) begin
            unique case (state_reg)
                HUNT:    state_next = ws_prev_reg ? LEFT : HUNT;
                LEFT:    state_next = ws_prev_reg ? HUNT : RIGHT;
                RIGHT:   state_next = ws_prev_reg ? LEFT : HUNT;
                default: state_next = HUNT;
            endcase
        end
    end

    always_comb begin
        left_done  = 1'b0;
        frame_done = 1'b0;
        if (word_edge) begin
            left_done  = (state_reg == LEFT)  && !ws_prev_reg;
            frame_done = (state_reg == RIGHT) &&  ws_prev_reg;
        end
    end

    always_ff @(posedge clk_ref) begin
        if (!reset_n) begin
            out_left_reg  <= '0;
            out_right_reg <= '0;
            out_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            overflow_reg <= 1'b0;
            if (frame_done) begin
                if (out_valid_reg && !out_ready) begin
                    overflow_reg <= 1'b1;
                end else begin
                    out_left_reg  <= left_stage_reg;
                    out_right_reg <= cur_word;
                    out_valid_reg <= 1'b1;
                end
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_left  = out_left_reg;
    assign out_right = out_right_reg;
    assign out_valid = out_valid_reg;
    assign overflow  = overflow_reg;

`ifdef I2S_RX_OVERFLOW_CNT_EN
    logic [15:0] ovf_cnt_reg;

    always_ff @(posedge clk_ref) begin
        if (!reset_n) begin
            ovf_cnt_reg <= '0;
        end else if (overflow_reg && (ovf_cnt_reg != 16'hFFFF)) begin
            ovf_cnt_reg <= ovf_cnt_reg + 16'd1;
        end
    end

    assign overflow_count = ovf_cnt_reg;
`else
    assign overflow_count = 16'h0000;
`endif

endmodule
